// File: rtl/cam_dvp_source_pkg.sv
// Shared types and constants for the DVP camera test-pattern source.
// The LFSR step helper is only used when DVP_SRC_LFSR_EN is defined.
package dvp_src_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        VSYNC  = 3'd1,
        VBACK  = 3'd2,
        LINE   = 3'd3,
        HBLANK = 3'd4,
        VFRONT = 3'd5
    } dvp_state_e;

    localparam logic [1:0] MODE_SOLID = 2'b00;
    localparam logic [1:0] MODE_HRAMP = 2'b01;
    localparam logic [1:0] MODE_VRAMP = 2'b10;
    localparam logic [1:0] MODE_ALT   = 2'b11;

    localparam logic [7:0] SOLID_VALUE = 8'h4C;
    localparam logic [7:0] LFSR_SEED   = 8'hA5;

    // Pattern for one pixel; MODE_ALT here is the 4x4 checkerboard.
    function automatic logic [7:0] dvp_pattern(input logic [1:0] sel,
                                               input logic [7:0] px,
                                               input logic [7:0] py);
        logic [7:0] pix;
        case (sel)
            MODE_SOLID: pix = SOLID_VALUE;
            MODE_HRAMP: pix = px;
            MODE_VRAMP: pix = py;
            default:    pix = (px[2] ^ py[2]) ? 8'hFF : 8'h00;
        endcase
        return pix;
    endfunction

    // Fibonacci step for x^8+x^6+x^5+x^4+1, shifting towards the MSB.
    function automatic logic [7:0] lfsr8_next(input logic [7:0] cur);
        return {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
    endfunction

endpackage

// File: rtl/cam_dvp_source_if.sv
// DVP video bus: frame sync, line valid and 8-bit pixel data.
interface cam_dvp_source_if;
    logic       cam_vsync;
    logic       cam_href;
    logic [7:0] cam_data;

    modport master (output cam_vsync, output cam_href, output cam_data);
    modport slave  (input  cam_vsync, input  cam_href, input  cam_data);
endinterface

// File: rtl/cam_dvp_source_lfsr.sv
// 8-bit pseudo-random pixel generator, present only with DVP_SRC_LFSR_EN.
// load reseeds to LFSR_SEED; step advances one pixel.
`ifdef DVP_SRC_LFSR_EN
module dvp_lfsr8
    import dvp_src_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       step,
    output logic [7:0] q
);
    logic [7:0] q_q;

    // Seed register, reloaded at every frame start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= LFSR_SEED;
        end else if (load) begin
            q_q <= LFSR_SEED;
        end else if (step) begin
            q_q <= lfsr8_next(q_q);
        end else begin
            q_q <= q_q;
        end
    end

    assign q = q_q;
endmodule
`endif

// File: rtl/cam_dvp_source.sv
// DVP camera test-pattern source: VSYNC/HREF framing with selectable patterns.
// Define DVP_SRC_LFSR_EN to replace the mode-11 checkerboard with an LFSR.
module cam_dvp_source
    import dvp_src_pkg::*;
#(
    parameter int H_ACTIVE = 16,
    parameter int V_ACTIVE = 12,
    parameter int H_BLANK  = 4,
    parameter int VSYNC_W  = 3,
    parameter int V_BACK   = 2,
    parameter int V_FRONT  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     continuous,
    input  logic [1:0]               mode,
    output logic                     busy,
    output logic                     frame_done,
    output logic [7:0]               frame_cnt,
    cam_dvp_source_if.master         dvp
);
    localparam logic [7:0]  H_LAST      = 8'(H_ACTIVE - 1);
    localparam logic [7:0]  V_LAST      = 8'(V_ACTIVE - 1);
    localparam logic [15:0] HBLANK_LAST = 16'(H_BLANK - 1);
    localparam logic [15:0] VSYNC_LAST  = 16'(VSYNC_W - 1);
    localparam logic [15:0] VBACK_LAST  = 16'(V_BACK - 1);
    localparam logic [15:0] VFRONT_LAST = 16'(V_FRONT - 1);

    dvp_state_e  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  x_q, x_d, y_q, y_d;
    logic [1:0]  mode_q, mode_d;
    logic        vsync_q, vsync_d, href_q, href_d;
    logic [7:0]  data_q, data_d, pix_s;
    logic        busy_q, busy_d, frame_done_q, frame_done_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;

    // Next-state decode; x_d/y_d always name the pixel shown next cycle.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        x_d          = x_q;
        y_d          = y_q;
        mode_d       = mode_q;
        vsync_d      = 1'b0;
        href_d       = 1'b0;
        frame_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = VSYNC;
                    vsync_d = 1'b1;
                    mode_d  = mode;
                    cnt_d   = 16'd0;
                    x_d     = 8'd0;
                    y_d     = 8'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            VSYNC: begin
                if (cnt_q == VSYNC_LAST) begin
                    state_d = VBACK;
                    cnt_d   = 16'd0;
                end else begin
                    vsync_d = 1'b1;
                    cnt_d   = cnt_q + 16'd1;
                end
            end
            VBACK: begin
                if (cnt_q == VBACK_LAST) begin
                    state_d = LINE;
                    cnt_d   = 16'd0;
                    href_d  = 1'b1;
                    x_d     = 8'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            LINE: begin
                if (x_q == H_LAST) begin
                    x_d   = 8'd0;
                    cnt_d = 16'd0;
                    // The last line skips HBLANK entirely.
                    if (y_q == V_LAST) begin
                        state_d      = VFRONT;
                        y_d          = 8'd0;
                        frame_done_d = (VFRONT_LAST == 16'd0);
                    end else begin
                        state_d = HBLANK;
                        y_d     = y_q + 8'd1;
                    end
                end else begin
                    href_d = 1'b1;
                    x_d    = x_q + 8'd1;
                end
            end
            HBLANK: begin
                if (cnt_q == HBLANK_LAST) begin
                    state_d = LINE;
                    cnt_d   = 16'd0;
                    href_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            VFRONT: begin
                if (cnt_q == VFRONT_LAST) begin
                    cnt_d = 16'd0;
                    if (continuous) begin
                        state_d = VSYNC;
                        vsync_d = 1'b1;
                        mode_d  = mode;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d        = cnt_q + 16'd1;
                    frame_done_d = ((cnt_q + 16'd1) == VFRONT_LAST);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 16'd0;
                x_d     = 8'd0;
                y_d     = 8'd0;
            end
        endcase
        busy_d      = (state_d != IDLE);
        frame_cnt_d = frame_cnt_q + {7'd0, frame_done_d};
    end

`ifdef DVP_SRC_LFSR_EN
    logic [7:0] lfsr_s;
    logic       lfsr_load_s;

    assign lfsr_load_s = (state_d == VSYNC) && (state_q != VSYNC);

    dvp_lfsr8 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (lfsr_load_s),
        .step  (href_d),
        .q     (lfsr_s)
    );

    // Pattern source for the next pixel, LFSR replacing the checkerboard.
    always_comb begin
        if (mode_q == MODE_ALT) begin
            pix_s = lfsr_s;
        end else begin
            pix_s = dvp_pattern(mode_q, x_d, y_d);
        end
    end
`else
    // Pattern source for the next pixel.
    always_comb begin
        pix_s = dvp_pattern(mode_q, x_d, y_d);
    end
`endif

    // Data bus is forced to zero outside active pixels.
    always_comb begin
        if (href_d) begin
            data_d = pix_s;
        end else begin
            data_d = 8'h00;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= 16'd0;
            x_q          <= 8'd0;
            y_q          <= 8'd0;
            mode_q       <= 2'b00;
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            data_q       <= 8'h00;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= 8'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            x_q          <= x_d;
            y_q          <= y_d;
            mode_q       <= mode_d;
            vsync_q      <= vsync_d;
            href_q       <= href_d;
            data_q       <= data_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign dvp.cam_vsync = vsync_q;
    assign dvp.cam_href  = href_q;
    assign dvp.cam_data  = data_q;
    assign busy          = busy_q;
    assign frame_done    = frame_done_q;
    assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_cam_dvp_source.sv
// Directed bench for cam_dvp_source with default geometry (243-cycle frames).
// Honours DVP_SRC_LFSR_EN for the mode-11 expectation.
module tb_cam_dvp_source;
    localparam int VS    = 3;
    localparam int VB    = 2;
    localparam int HA    = 16;
    localparam int HB    = 4;
    localparam int VA    = 12;
    localparam int FRAME = 243;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       continuous = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       busy, frame_done;
    logic [7:0] frame_cnt;
    int         n_checks = 0;
    int         n_errors = 0;

    cam_dvp_source_if dvp_bus ();

    cam_dvp_source #(
        .H_ACTIVE (16), .V_ACTIVE (12), .H_BLANK (4),
        .VSYNC_W  (3),  .V_BACK   (2),  .V_FRONT (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .continuous (continuous),
        .mode       (mode),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt),
        .dvp        (dvp_bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_vsync"}, {31'd0, dvp_bus.cam_vsync}, 32'd0);
        check_val({tag, "_href"},  {31'd0, dvp_bus.cam_href}, 32'd0);
        check_val({tag, "_data"},  {24'd0, dvp_bus.cam_data}, 32'd0);
        check_val({tag, "_busy"},  {31'd0, busy}, 32'd0);
        check_val({tag, "_done"},  {31'd0, frame_done}, 32'd0);
        check_val({tag, "_fcnt"},  {24'd0, frame_cnt}, 32'd0);
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, "_busy"},  {31'd0, busy}, 32'd0);
        check_val({tag, "_vsync"}, {31'd0, dvp_bus.cam_vsync}, 32'd0);
        check_val({tag, "_href"},  {31'd0, dvp_bus.cam_href}, 32'd0);
    endtask

    // Walks one frame from its first VSYNC cycle, sampling on negedges.
    // At cycle poke_at the inputs start/continuous/mode are rewritten.
    task automatic run_frame(input string tag, input logic [1:0] m, input logic [7:0] exp_cnt,
                             input int poke_at, input logic p_start, input logic p_cont,
                             input logic [1:0] p_mode);
        int         err_vs, err_hr, err_dt, err_fd, err_bz, o;
        logic       e_vs, e_hr, e_fd;
        logic [7:0] e_dt, ex, ey, lf;
        err_vs = 0; err_hr = 0; err_dt = 0; err_fd = 0; err_bz = 0;
        lf = 8'hA5;
        for (int c = 1; c <= FRAME; c++) begin
            @(negedge clk);
            o    = c - (VS + VB + 1);
            e_vs = (c <= VS);
            e_hr = (o >= 0) && ((o / (HA + HB)) < VA) && ((o % (HA + HB)) < HA);
            e_fd = (c == FRAME);
            ex   = 8'(o % (HA + HB));
            ey   = 8'(o / (HA + HB));
            e_dt = 8'h00;
            if (e_hr) begin
                case (m)
                    2'b00:   e_dt = 8'h4C;
                    2'b01:   e_dt = ex;
                    2'b10:   e_dt = ey;
`ifdef DVP_SRC_LFSR_EN
                    default: e_dt = lf;
`else
                    default: e_dt = (ex[2] ^ ey[2]) ? 8'hFF : 8'h00;
`endif
                endcase
                lf = {lf[6:0], lf[7] ^ lf[5] ^ lf[4] ^ lf[3]};
            end
            if (dvp_bus.cam_vsync !== e_vs) err_vs++;
            if (dvp_bus.cam_href !== e_hr)  err_hr++;
            if (dvp_bus.cam_data !== e_dt)  err_dt++;
            if (frame_done !== e_fd)        err_fd++;
            if (busy !== 1'b1)              err_bz++;
            if (c == FRAME) check_val({tag, "_fcnt"}, {24'd0, frame_cnt}, {24'd0, exp_cnt});
            if (c == poke_at) begin
                start      = p_start;
                continuous = p_cont;
                mode       = p_mode;
            end
        end
        check_val({tag, "_vsync_bad"}, err_vs, 32'd0);
        check_val({tag, "_href_bad"},  err_hr, 32'd0);
        check_val({tag, "_data_bad"},  err_dt, 32'd0);
        check_val({tag, "_done_bad"},  err_fd, 32'd0);
        check_val({tag, "_busy_bad"},  err_bz, 32'd0);
    endtask

    initial begin
        int act;
        #12;
        check_all_zero("rst");
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_idle("nostart");

        // Single horizontal-ramp frame.
        mode = 2'b01; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        run_frame("t1", 2'b01, 8'd1, 0, 1'b0, 1'b0, 2'b01);
        @(negedge clk);
        check_idle("t1_end");
        check_val("t1_cnt", {24'd0, frame_cnt}, 32'd1);

        // Back-to-back vertical-ramp frames; continuous dropped mid third frame.
        mode = 2'b10; continuous = 1'b1; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        run_frame("t2a", 2'b10, 8'd2, 0, 1'b0, 1'b1, 2'b10);
        run_frame("t2b", 2'b10, 8'd3, 0, 1'b0, 1'b1, 2'b10);
        run_frame("t2c", 2'b10, 8'd4, 100, 1'b0, 1'b0, 2'b10);
        @(negedge clk);
        check_idle("t2_end");

        // Mode switched mid-frame only applies from the next frame.
        mode = 2'b00; continuous = 1'b1; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        run_frame("t3a", 2'b00, 8'd5, 50, 1'b0, 1'b1, 2'b11);
        run_frame("t3b", 2'b11, 8'd6, 10, 1'b0, 1'b0, 2'b11);
        @(negedge clk);
        check_idle("t3_end");

        // start held high: ignored while busy, relaunches after one idle cycle.
        mode = 2'b01; continuous = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        run_frame("t4a", 2'b01, 8'd7, 0, 1'b1, 1'b0, 2'b01);
        @(negedge clk);
        check_idle("t4_gap");
        run_frame("t4b", 2'b01, 8'd8, 5, 1'b0, 1'b0, 2'b01);
        @(negedge clk);
        check_idle("t4_end");

        // Asynchronous reset in the middle of line 5 (pixel x=3).
        mode = 2'b01; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (109) @(negedge clk);
        check_val("t5_href", {31'd0, dvp_bus.cam_href}, 32'd1);
        check_val("t5_data", {24'd0, dvp_bus.cam_data}, 32'd3);
        #1 rst_n = 1'b0;
        #1 check_all_zero("t5_rst");
        @(negedge clk) rst_n = 1'b1;
        act = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (busy || dvp_bus.cam_vsync || dvp_bus.cam_href || (dvp_bus.cam_data != 8'h00)) act++;
        end
        check_val("t5_quiet", act, 32'd0);

        // 256 solid frames: frame_cnt wraps to zero on the last one.
        mode = 2'b00; continuous = 1'b1; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 1; i <= 256; i++) begin
            run_frame("t6", 2'b00, 8'(i), (i == 256) ? 10 : 0, 1'b0, (i != 256), 2'b00);
        end
        @(negedge clk);
        check_idle("t6_end");
        check_val("t6_wrap", {24'd0, frame_cnt}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/cam_dvp_source.md
CAM_DVP_SOURCE -- requirements
Module: cam_dvp_source

Interface
REQ-001 Parameter H_ACTIVE, 16, active pixels per line (2..255).
REQ-002 Parameter V_ACTIVE, 12, active lines per frame (1..255).
REQ-003 Parameter H_BLANK, 4, HREF-low cycles between active lines (>=1).
REQ-004 Parameter VSYNC_W, 3, VSYNC-high cycles (>=1).
REQ-005 Parameter V_BACK, 2, cycles from VSYNC fall to first HREF rise (>=1).
REQ-006 Parameter V_FRONT, 2, cycles after last HREF fall before frame end (>=1).
REQ-007 clk  input  1  system clock; also the pixel clock, one pixel per cycle.
REQ-008 rst_n  input  1  reset, asynchronous, active-low.
REQ-009 start  input  1  level; sampled in IDLE, launches a frame.
REQ-010 continuous  input  1  high: next frame starts immediately after the current one.
REQ-011 mode  input  2  pattern select: 00 solid, 01 horizontal ramp, 10 vertical ramp, 11 checker/noise.
REQ-012 cam_vsync  output  1  frame sync, active high.
REQ-013 cam_href  output  1  line valid, active high.
REQ-014 cam_data  output  8  pixel data; 8'h00 whenever cam_href is low.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 frame_done  output  1  one-cycle pulse on the last V_FRONT cycle.
REQ-017 frame_cnt  output  8  completed frames, wraps 255->0.

Function
REQ-018 The FSM SHALL have the states IDLE, VSYNC, VBACK, LINE, HBLANK and VFRONT; all outputs are registered.
REQ-019 IDLE with start=1 at edge N SHALL give cam_vsync=1 from edge N+1 for VSYNC_W cycles; mode is latched at that edge and held for the whole frame.
REQ-020 VSYNC->VBACK (V_BACK cycles, all low)->LINE (cam_href=1 for H_ACTIVE cycles)->HBLANK (H_BLANK cycles)->LINE, repeated for V_ACTIVE lines.
REQ-021 After the last line, LINE SHALL go directly to VFRONT, with no HBLANK.
REQ-022 Frame length SHALL equal VSYNC_W+V_BACK+V_ACTIVE*H_ACTIVE+(V_ACTIVE-1)*H_BLANK+V_FRONT cycles (default 243).
REQ-023 Pixel coordinates x (0..H_ACTIVE-1) and y (0..V_ACTIVE-1) SHALL count active pixels only.
REQ-024 Patterns: 00 -> 8'h4C; 01 -> x[7:0]; 10 -> y[7:0]; 11 -> (x[2]^y[2]) ? 8'hFF : 8'h00.
REQ-025 The VFRONT last cycle SHALL assert frame_done and increment frame_cnt on the same edge.
REQ-026 After VFRONT, continuous=1 SHALL go to VSYNC with no IDLE cycle, relatching mode; continuous=0 SHALL go to IDLE.
REQ-027 start while busy SHALL be ignored; continuous deasserted mid-frame SHALL let the frame complete.
REQ-028 mode changes mid-frame SHALL have no effect until the next frame start.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, with cam_vsync=0, cam_href=0, cam_data=0, busy=0, frame_done=0, frame_cnt=0, and x, y and all counters 0, including mid-frame.
REQ-030 After rst_n rises, the first frame SHALL need a fresh start sample.

Configuration
REQ-031 Macro DVP_SRC_LFSR_EN defined: mode 11 SHALL output an 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1), seeded 8'hA5 at reset and at every frame start, advancing once per active pixel, so the first pixel is 8'hA5.
REQ-032 Macro DVP_SRC_LFSR_EN undefined: mode 11 SHALL output the checkerboard, and no LFSR logic SHALL exist.

Structure
REQ-033 Package dvp_src_pkg SHALL hold the FSM state enum, the mode constants (MODE_SOLID, MODE_HRAMP, MODE_VRAMP, MODE_ALT) and SOLID_VALUE=8'h4C.
REQ-034 The LFSR SHALL be sub-module dvp_lfsr8 (ports clk, rst_n, load, step, q), instantiated only under DVP_SRC_LFSR_EN.

Verification
REQ-035 Reset, then start=1 for one cycle, mode=01 -> vsync high 3 cycles, first href 2 cycles later, line data 00..0F, frame_done at cycle 243, frame_cnt=1, busy low.
REQ-036 continuous=1, mode=10 -> back-to-back frames with no idle gap; line k data all k; frame_cnt counts 1,2,3.
REQ-037 mode switched 00->11 mid-frame -> current frame stays 8'h4C; next frame is checker, or LFSR starting A5 under DVP_SRC_LFSR_EN.
REQ-038 rst_n pulsed low during LINE of line 5 -> all outputs 0 at once; no activity until next start.
REQ-039 start held high through a frame with continuous=0 -> start ignored while busy; a new frame begins one cycle after IDLE is reached.
REQ-040 frame_cnt preloaded to 255 via 255 frames -> the 256th frame_done wraps it to 0; cam_data=0 whenever href=0 throughout.
